// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: per-register pending-write counters that stall
// issue on RAW hazards and on counter saturation, released by writeback strobes.
module reg_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int CNT_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid,
  input  logic                    issue_use_src1,
  input  logic [ADDR_W-1:0]       issue_src1,
  input  logic                    issue_use_src2,
  input  logic [ADDR_W-1:0]       issue_src2,
  input  logic                    issue_has_dst,
  input  logic [ADDR_W-1:0]       issue_dst,
  output logic                    issue_ready,
  output logic                    stall,
  input  logic                    wb_valid,
  input  logic [ADDR_W-1:0]       wb_addr,
  output logic [NUM_REGS-1:0]     busy_mask,
  output logic [CNT_W+ADDR_W-1:0] outstanding,
  output logic                    err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic                hazard;
  logic                sat_block;
  logic                accept;
  logic                claim;
  logic                retire;
  logic                underflow;
  logic                wb_self_claim;
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;

  always_comb begin
    hazard        = (issue_use_src1 && (cnt[issue_src1] != '0)) ||
                    (issue_use_src2 && (cnt[issue_src2] != '0));
    sat_block     = issue_has_dst && (cnt[issue_dst] == CNT_MAX);
    issue_ready   = !rst && !hazard && !sat_block;
    stall         = issue_valid && !issue_ready;
    accept        = issue_valid && issue_ready;
    claim         = accept && issue_has_dst;
    wb_self_claim = claim && (issue_dst == wb_addr);
    // A writeback to an idle register is legal only if it retires this cycle's claim.
    retire        = wb_valid && ((cnt[wb_addr] != '0) || wb_self_claim);
    underflow     = wb_valid && (cnt[wb_addr] == '0) && !wb_self_claim;
  end

  always_comb begin
    inc       = '0;
    dec       = '0;
    busy_mask = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      inc[i]       = claim  && (issue_dst == ADDR_W'(i));
      dec[i]       = retire && (wb_addr   == ADDR_W'(i));
      busy_mask[i] = (cnt[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt[i] <= '0;
      end
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (inc[i] && !dec[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (dec[i] && !inc[i]) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
      if (claim && !retire) begin
        outstanding <= outstanding + 1'b1;
      end else if (retire && !claim) begin
        outstanding <= outstanding - 1'b1;
      end
      if (underflow) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios followed by random traffic,
// all checked against a per-register pending-count reference model.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, issue_use_src1, issue_use_src2, issue_has_dst;
  logic [2:0] issue_src1, issue_src2, issue_dst;
  logic       issue_ready, stall;
  logic       wb_valid;
  logic [2:0] wb_addr;
  logic [7:0] busy_mask;
  logic [4:0] outstanding;
  logic       err_underflow;

  int total = 0;
  int bad   = 0;

  int m_cnt [8];
  bit m_err;
  bit m_known = 0;

  reg_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_use_src1(issue_use_src1), .issue_src1(issue_src1),
    .issue_use_src2(issue_use_src2), .issue_src2(issue_src2),
    .issue_has_dst(issue_has_dst), .issue_dst(issue_dst),
    .issue_ready(issue_ready), .stall(stall),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .busy_mask(busy_mask), .outstanding(outstanding), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    if (rst) return 0;
    if (issue_use_src1 && m_cnt[issue_src1] > 0) return 0;
    if (issue_use_src2 && m_cnt[issue_src2] > 0) return 0;
    if (issue_has_dst && m_cnt[issue_dst] == 3) return 0;
    return 1;
  endfunction

  function automatic int m_sum();
    int s = 0;
    for (int i = 0; i < 8; i++) s += m_cnt[i];
    return s;
  endfunction

  function automatic logic [7:0] m_busy();
    logic [7:0] b = '0;
    for (int i = 0; i < 8; i++) b[i] = (m_cnt[i] > 0);
    return b;
  endfunction

  // Check against the model at the falling edge, then advance the model over the rising edge.
  task automatic step();
    bit rdy;
    @(negedge clk);
    rdy = m_ready();
    chk("m_ready", {31'd0, issue_ready}, {31'd0, rdy});
    chk("m_stall", {31'd0, stall}, {31'd0, issue_valid && !rdy});
    if (m_known) begin
      chk("m_busy", {24'd0, busy_mask}, {24'd0, m_busy()});
      chk("m_outstanding", {27'd0, outstanding}, m_sum());
      chk("m_err", {31'd0, err_underflow}, {31'd0, m_err});
    end
    if (rst) begin
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      m_err = 0;
    end else begin
      // A claim lands first, so a same-cycle writeback to it retires it cleanly.
      if (issue_valid && rdy && issue_has_dst) m_cnt[issue_dst]++;
      if (wb_valid) begin
        if (m_cnt[wb_addr] > 0) m_cnt[wb_addr]--;
        else m_err = 1;
      end
    end
    @(posedge clk);
    m_known = 1;
    #1;
  endtask

  task automatic set_issue(input bit v, input bit u1, input int s1, input bit u2,
                           input int s2, input bit hd, input int d);
    issue_valid = v; issue_use_src1 = u1; issue_src1 = 3'(s1);
    issue_use_src2 = u2; issue_src2 = 3'(s2); issue_has_dst = hd; issue_dst = 3'(d);
  endtask

  task automatic set_wb(input bit v, input int a);
    wb_valid = v; wb_addr = 3'(a);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    m_err = 0;
    rst = 1;
    set_issue(1, 0, 0, 0, 0, 0, 0);
    set_wb(1, 4);
    #1;
    chk("rst_ready", {31'd0, issue_ready}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd1);
    step(); step();
    chk("rst_busy", {24'd0, busy_mask}, 32'h00);
    chk("rst_outstanding", {27'd0, outstanding}, 32'd0);
    chk("rst_err", {31'd0, err_underflow}, 32'd0);

    rst = 0; set_wb(0, 0); set_issue(0, 0, 0, 0, 0, 0, 0); #1;
    chk("idle_ready", {31'd0, issue_ready}, 32'd1);
    chk("idle_stall", {31'd0, stall}, 32'd0);
    step();

    // RAW hazard on R3
    set_issue(1, 0, 0, 0, 0, 1, 3); #1;
    chk("raw_claim_ready", {31'd0, issue_ready}, 32'd1);
    step();
    set_issue(1, 1, 3, 0, 0, 0, 0); #1;
    chk("raw_stall", {31'd0, stall}, 32'd1);
    chk("raw_busy", {24'd0, busy_mask}, 32'h08);
    step();
    set_wb(1, 3); #1;
    chk("raw_wb_cycle_stall", {31'd0, stall}, 32'd1);
    step();
    set_wb(0, 0); #1;
    chk("raw_after_wb_ready", {31'd0, issue_ready}, 32'd1);
    chk("raw_after_wb_busy", {24'd0, busy_mask}, 32'h00);
    step();

    // Saturation on R5
    set_issue(1, 0, 0, 0, 0, 1, 5);
    step(); step(); step();
    #1;
    chk("sat_ready", {31'd0, issue_ready}, 32'd0);
    chk("sat_outstanding", {27'd0, outstanding}, 32'd3);
    chk("sat_busy", {24'd0, busy_mask}, 32'h20);
    set_wb(1, 5); #1;
    chk("sat_wb_cycle_ready", {31'd0, issue_ready}, 32'd0);
    step();
    set_wb(0, 0); #1;
    chk("sat_release_ready", {31'd0, issue_ready}, 32'd1);
    step();
    set_issue(0, 0, 0, 0, 0, 0, 0); set_wb(1, 5);
    step(); step(); step();
    set_wb(0, 0); #1;
    chk("sat_drained", {27'd0, outstanding}, 32'd0);

    // Simultaneous claim and retire on R2
    set_issue(1, 0, 0, 0, 0, 1, 2);
    step();
    set_wb(1, 2); #1;
    chk("sim_ready", {31'd0, issue_ready}, 32'd1);
    step();
    set_issue(0, 0, 0, 0, 0, 0, 0); set_wb(0, 0); #1;
    chk("sim_busy2", {31'd0, busy_mask[2]}, 32'd1);
    chk("sim_outstanding", {27'd0, outstanding}, 32'd1);
    chk("sim_err", {31'd0, err_underflow}, 32'd0);
    set_wb(1, 2); step(); set_wb(0, 0);

    // Underflow on R6
    set_wb(1, 6); step(); set_wb(0, 0); #1;
    chk("uf_err", {31'd0, err_underflow}, 32'd1);
    chk("uf_outstanding", {27'd0, outstanding}, 32'd0);
    for (int i = 0; i < 10; i++) step();
    chk("uf_held", {31'd0, err_underflow}, 32'd1);
    rst = 1; step(); rst = 0; #1;
    chk("uf_cleared", {31'd0, err_underflow}, 32'd0);

    // Mid-operation reset with R2, R3, R5, R5 pending
    set_issue(1, 0, 0, 0, 0, 1, 2); step();
    set_issue(1, 0, 0, 0, 0, 1, 3); step();
    set_issue(1, 0, 0, 0, 0, 1, 5); step(); step();
    set_issue(0, 0, 0, 0, 0, 0, 0); #1;
    chk("mid_busy", {24'd0, busy_mask}, 32'h2C);
    chk("mid_outstanding", {27'd0, outstanding}, 32'd4);
    rst = 1; step(); rst = 0;
    set_issue(1, 1, 2, 0, 0, 0, 0); #1;
    chk("mid_rst_busy", {24'd0, busy_mask}, 32'h00);
    chk("mid_rst_outstanding", {27'd0, outstanding}, 32'd0);
    chk("mid_rst_ready", {31'd0, issue_ready}, 32'd1);
    step();

    // Random traffic; issue fields are held while stalled
    for (int n = 0; n < 600; n++) begin
      int pick;
      if (!(issue_valid && !m_ready()) || rst) begin
        set_issue($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 7));
      end
      pick = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0)
        for (int k = 0; k < 8; k++) if (m_cnt[(pick + k) % 8] > 0) begin pick = (pick + k) % 8; break; end
      set_wb($urandom_range(0, 2) == 0, pick);
      rst = ($urandom_range(0, 79) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
